// File: rtl/madd_pipe_pkg.sv
// madd_pipe shared definitions: operation encoding and signed range helpers.
package madd_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_MAC = 2'b00,
    MODE_MSC = 2'b01,
    MODE_ACC = 2'b10,
    MODE_LDA = 2'b11
  } mode_e;

  function automatic logic signed [127:0] smax(input int w);
    return (128'sd1 <<< (w - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] smin(input int w);
    return -(128'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/madd_booth_tree.sv
// Radix-4 Booth partial products reduced to a carry-save pair.
module madd_booth_tree
  import madd_pipe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] sum_o,
  output logic [2*WIDTH-1:0] cry_o
);

  localparam int P   = 2 * WIDTH;
  localparam int NPP = WIDTH / 2 + 1;

  logic [P-1:0] pp [NPP];
  logic [P-1:0] ae;
  logic [WIDTH:0] bx;

  assign ae = {{WIDTH{a_i[WIDTH-1]}}, a_i};
  assign bx = {b_i, 1'b0};

  // Negation is ~mag here; the +1 of each negative digit goes in the last row.
  always_comb begin
    logic [P-1:0] mag;
    logic [P-1:0] cor;
    logic one, two, neg;
    cor = '0;
    mag = '0;
    one = 1'b0;
    two = 1'b0;
    neg = 1'b0;
    for (int i = 0; i < NPP; i++) pp[i] = '0;
    for (int i = 0; i < NPP - 1; i++) begin
      neg = bx[2*i+2];
      one = bx[2*i+1] ^ bx[2*i];
      two = (bx[2*i+2] & ~bx[2*i+1] & ~bx[2*i]) |
            (~bx[2*i+2] & bx[2*i+1] & bx[2*i]);
      mag = one ? ae : (two ? (ae << 1) : '0);
      pp[i] = (neg ? ~mag : mag) << (2 * i);
      cor[2*i] = neg;
    end
    pp[NPP-1] = cor;
  end

  always_comb begin
    logic [P-1:0] s, c, x;
    s = pp[0];
    c = pp[1];
    x = '0;
    for (int i = 2; i < NPP; i++) begin
      x = pp[i];
      {s, c} = {s ^ c ^ x, ((s & c) | (s & x) | (c & x)) << 1};
    end
    sum_o = s;
    cry_o = c;
  end

endmodule

// File: rtl/madd_pipe.sv
// Pipelined signed multiply-add with accumulator and valid/ready handshake.
// Define MADD_PIPE_SAT_EN to saturate results to the signed WIDTH range.
module madd_pipe
  import madd_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [1:0]       MODE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Z,
  output logic             BUSY
);

  localparam int P = 2 * WIDTH;
  localparam int L = STAGES - 1;

  logic [P-1:0]     bs, bc;
  logic             stall, adv, acc_ld;
  logic [L:1]       vld_q;
  logic [P-1:0]     s_q  [1:L];
  logic [P-1:0]     cy_q [1:L];
  logic [WIDTH-1:0] c_q  [1:L];
  mode_e            md_q [1:L];
  logic [WIDTH-1:0] z_q, z_d, acc_q;
  logic             ov_q;
  logic [P-1:0]     ext, add;
  logic signed [P-1:0] full;

  madd_booth_tree #(.WIDTH(WIDTH)) u_tree (
    .a_i   (A),
    .b_i   (B),
    .sum_o (bs),
    .cry_o (bc)
  );

  assign stall     = ov_q & ~OUT_READY;
  assign adv       = ~stall;
  assign IN_READY  = ~stall & ~RST;
  assign OUT_VALID = ov_q;
  assign Z         = z_q;
  assign BUSY      = (|vld_q) | ov_q;

  assign acc_ld = vld_q[L] &
                  (md_q[L] == MODE_ACC || md_q[L] == MODE_LDA);

  always_comb begin
    ext = {{WIDTH{c_q[L][WIDTH-1]}}, c_q[L]};
    add = ext;
    unique case (md_q[L])
      MODE_MSC: add = -ext;
      MODE_ACC: add = {{WIDTH{acc_q[WIDTH-1]}}, acc_q};
      MODE_MAC,
      MODE_LDA: add = ext;
    endcase
    full = $signed(s_q[L] + cy_q[L] + add);
  end

`ifdef MADD_PIPE_SAT_EN
  localparam logic signed [127:0] SMAX = smax(WIDTH);
  localparam logic signed [127:0] SMIN = smin(WIDTH);

  always_comb begin
    z_d = full[WIDTH-1:0];
    if (full > $signed(SMAX[P-1:0]))
      z_d = SMAX[WIDTH-1:0];
    else if (full < $signed(SMIN[P-1:0]))
      z_d = SMIN[WIDTH-1:0];
  end
`else
  logic unused_hi;
  assign unused_hi = ^full[P-1:WIDTH];
  assign z_d       = full[WIDTH-1:0];
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_q <= '0;
      ov_q  <= 1'b0;
      z_q   <= '0;
      acc_q <= '0;
    end else if (adv) begin
      vld_q[1] <= IN_VALID;
      for (int i = 2; i <= L; i++) vld_q[i] <= vld_q[i-1];
      ov_q <= vld_q[L];
      if (vld_q[L]) z_q <= z_d;
      if (acc_ld) acc_q <= z_d;
    end
  end

  // Payload registers need no reset; their valid bits qualify them.
  always_ff @(posedge CLK) begin
    if (adv) begin
      s_q[1]  <= bs;
      cy_q[1] <= bc;
      c_q[1]  <= C;
      md_q[1] <= mode_e'(MODE);
      for (int i = 2; i <= L; i++) begin
        s_q[i]  <= s_q[i-1];
        cy_q[i] <= cy_q[i-1];
        c_q[i]  <= c_q[i-1];
        md_q[i] <= md_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_madd_pipe.sv
// Directed self-checking bench for madd_pipe (WIDTH=32, STAGES=3).
module tb_madd_pipe;
  import madd_pipe_pkg::*;

  logic        CLK, RST, IN_VALID, IN_READY;
  logic [31:0] A, B, C, Z;
  logic [1:0]  MODE;
  logic        OUT_VALID, OUT_READY, BUSY;

  int total = 0;
  int bad   = 0;

`ifdef MADD_PIPE_SAT_EN
  localparam logic [31:0] E_OVF = 32'h7FFF_FFFF;
  localparam logic [31:0] E_BIG = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] E_OVF = 32'hFFFF_FFFE;
  localparam logic [31:0] E_BIG = 32'h0000_0005;
`endif

  madd_pipe #(.WIDTH(32), .STAGES(3)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .A         (A),
    .B         (B),
    .C         (C),
    .MODE      (MODE),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .Z         (Z),
    .BUSY      (BUSY)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [1:0] m,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] c);
    IN_VALID = v;
    MODE     = m;
    A        = a;
    B        = b;
    C        = c;
  endtask

  task automatic run1(input string tag, input logic [1:0] m,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [31:0] e);
    drv(1'b1, m, a, b, c);
    tick();
    drv(1'b0, 2'b00, '0, '0, '0);
    tick();
    tick();
    chk({tag, "_ov"}, 64'(OUT_VALID), 64'd1);
    chk(tag, 64'(Z), 64'(e));
    tick();
  endtask

  initial begin
    RST = 1'b1;
    OUT_READY = 1'b1;
    drv(1'b0, 2'b00, '0, '0, '0);
    tick();
    tick();
    chk("rst_ov", 64'(OUT_VALID), 64'd0);
    chk("rst_z", 64'(Z), 64'd0);
    chk("rst_in_ready", 64'(IN_READY), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    RST = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(IN_READY), 64'd1);

    drv(1'b1, MODE_MAC, 32'd3, 32'd5, 32'd7);
    tick();
    drv(1'b1, MODE_MSC, 32'hFFFF_FFFE, 32'd4, 32'd1);
    tick();
    drv(1'b0, 2'b00, '0, '0, '0);
    tick();
    chk("mac_ov", 64'(OUT_VALID), 64'd1);
    chk("mac_z", 64'(Z), 64'd22);
    tick();
    chk("msc_z", 64'(Z), 64'hFFFF_FFF7);
    tick();
    chk("drain_ov", 64'(OUT_VALID), 64'd0);
    chk("drain_busy", 64'(BUSY), 64'd0);

    drv(1'b1, MODE_LDA, 32'd2, 32'd3, 32'd10);
    tick();
    drv(1'b1, MODE_ACC, 32'd4, 32'd5, 32'd0);
    tick();
    drv(1'b0, 2'b00, '0, '0, '0);
    tick();
    chk("lda_z", 64'(Z), 64'd16);
    tick();
    chk("acc_z", 64'(Z), 64'd36);
    tick();
    run1("acc_read", MODE_ACC, 32'd0, 32'd0, 32'd0, 32'd36);

    run1("ovf", MODE_MAC, 32'h7FFF_FFFF, 32'd2, 32'd0, E_OVF);
    run1("big", MODE_MAC, 32'h8000_0000, 32'h8000_0000, 32'd5, E_BIG);
    run1("neg_msc", MODE_MSC, 32'hFFFF_FFFD, 32'hFFFF_FFF9,
         32'hFFFF_FF9C, 32'd121);

    drv(1'b1, MODE_LDA, 32'd1, 32'd1, 32'd5);
    tick();
    drv(1'b1, MODE_ACC, 32'd2, 32'd2, 32'd0);
    tick();
    drv(1'b1, MODE_ACC, 32'd3, 32'd3, 32'd0);
    tick();
    drv(1'b0, 2'b00, '0, '0, '0);
    chk("chain0", 64'(Z), 64'd6);
    tick();
    chk("chain1", 64'(Z), 64'd10);
    tick();
    chk("chain2", 64'(Z), 64'd19);
    tick();

    OUT_READY = 1'b0;
    drv(1'b1, MODE_MAC, 32'd1, 32'd1, 32'd0);
    tick();
    drv(1'b1, MODE_MAC, 32'd2, 32'd2, 32'd0);
    tick();
    drv(1'b1, MODE_MAC, 32'd3, 32'd3, 32'd0);
    tick();
    drv(1'b1, MODE_MAC, 32'd4, 32'd4, 32'd0);
    chk("stall_first", 64'(Z), 64'd1);
    chk("stall_in_ready", 64'(IN_READY), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("stall_hold_z", 64'(Z), 64'd1);
    chk("stall_hold_ov", 64'(OUT_VALID), 64'd1);
    chk("stall_hold_ir", 64'(IN_READY), 64'd0);
    OUT_READY = 1'b1;
    tick();
    drv(1'b0, 2'b00, '0, '0, '0);
    chk("resume0", 64'(Z), 64'd4);
    tick();
    chk("resume1", 64'(Z), 64'd9);
    tick();
    chk("resume2", 64'(Z), 64'd16);
    tick();
    chk("resume_end_ov", 64'(OUT_VALID), 64'd0);

    drv(1'b1, MODE_MAC, 32'd5, 32'd5, 32'd0);
    tick();
    drv(1'b1, MODE_MAC, 32'd6, 32'd6, 32'd0);
    tick();
    drv(1'b0, 2'b00, '0, '0, '0);
    RST = 1'b1;
    tick();
    chk("flush_ov", 64'(OUT_VALID), 64'd0);
    chk("flush_z", 64'(Z), 64'd0);
    chk("flush_busy", 64'(BUSY), 64'd0);
    RST = 1'b0;
    tick();
    tick();
    chk("flush_no_result", 64'(OUT_VALID), 64'd0);
    run1("acc_after_rst", MODE_ACC, 32'd1, 32'd1, 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
